memory_responder: RTL
=====================

# memory_responder

Synchronous word-addressed RAM that serves the datapath's memory-access port, forming the memory side of the MAR/MDR interface. It accepts a Read or Write request from the CPU control unit, inserts a programmable number of wait states, then completes the access and raises MFC (memory function complete). MFC stays high until the requester drops the request. Read data is driven toward the MDR's memory-data input; write data is taken from the MDR output.

## Interface
- ADDR_WIDTH, 9: word-address bits used; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: word width.
- WAIT_STATES, 2: extra busy cycles per access (0..15).
- INIT_FILE, "": hex image loaded at elaboration if non-empty; otherwise contents are undefined.
- clock  in  1  Single clock; all state updates on the rising edge.
- clear  in  1  Asynchronous, active-low reset.
- Read  in  1  Read request level, held until MFC.
- Write  in  1  Write request level, held until MFC.
- address  in  32  Byte-free word address from MAR; only [ADDR_WIDTH-1:0] is used.
- data_in  in  DATA_WIDTH  Write data from MDR output.
- data_out  out  DATA_WIDTH  Read data to MDR memory-data input.
- MFC  out  1  Access complete; high in DONE state.
- busy  out  1  High in BUSY state.
- req_error  out  1  One-cycle pulse: Read and Write both high in IDLE.

## Operation
- States: IDLE, BUSY, DONE. 4-bit wait counter `cnt`.
- Reset (clear=0, asynchronous): state=IDLE, cnt=0, data_out=0, MFC=0, busy=0, req_error=0. Memory array is not cleared.
- IDLE:
  - Exactly one of Read/Write high at the edge: latch address[ADDR_WIDTH-1:0], data_in and the request kind. Set cnt=WAIT_STATES and go to BUSY.
  - Both high: stay IDLE, pulse req_error for one cycle, perform no access.
  - Neither high: stay IDLE.
- BUSY:
  - Latched request kind still high and cnt==0: perform the access. Read loads data_out from mem[latched addr]; Write stores latched data into mem[latched addr]. Go to DONE.
  - Latched request kind still high and cnt!=0: cnt--.
  - Latched request kind deasserted: abort to IDLE. No write occurs and data_out is unchanged.
- DONE: MFC=1. When the latched request kind goes low, go to IDLE at the next edge. MFC clears at that same edge.
- Address wrap: upper address bits are ignored, so address 0x205 with ADDR_WIDTH=9 accesses word 0x005.
- Changes to address or data_in after acceptance have no effect on the access in flight.
- data_out holds its last read value through writes and idle periods.
- Reset in BUSY: access is aborted; no memory write.
- Reset in DONE: a write has already committed; MFC drops immediately.

## Timing
- Acceptance edge E0. MFC rises after edge E0+WAIT_STATES+1. With the default WAIT_STATES=2, MFC rises after E3.
- data_out is valid from the same edge at which MFC rises. The MDR may latch on the first edge where MFC=1.
- The request must be held until MFC is observed. Deassertion is seen at the next edge, and MFC falls after that edge.
- Minimum turnaround: one IDLE cycle between accesses. The next request is accepted at the edge after returning to IDLE if it is already high.
- busy is high for exactly WAIT_STATES+1 cycles per completed access.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset: hold clear=0 with Read=1. Check data_out=0, MFC=0 and busy=0. Release clear: access accepted at the first edge, MFC after 3 more edges.
- Write then read:
  - Write 0xDEADBEEF to address 0x10. MFC rises 3 edges after acceptance.
  - Drop Write, then Read 0x10. data_out=0xDEADBEEF with MFC after 3 edges.
  - MFC stays high while Read is held, then falls one edge after Read drops.
- Abort: Write 0x12345678 to 0x20, deassert Write after 1 BUSY edge. Check return to IDLE with MFC never high. A later read of 0x20 returns the prior contents, not 0x12345678.
- Conflict: Read=Write=1 in IDLE. Check req_error pulses for one cycle, busy stays 0, MFC stays 0, memory unchanged.
- Wrap: write 0xA5A5A5A5 to address 0x0000_0205 (ADDR_WIDTH=9). A read of address 0x005 returns 0xA5A5A5A5.
- Reset during BUSY of a write to 0x30: pull clear low mid-wait. A subsequent read of 0x30 returns the old value, and all outputs are at reset values while clear=0.

Source files
------------

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : memory_responder
// Purpose  : Word-addressed synchronous RAM on the memory side of a MAR/MDR
//            interface. Accepts level-held Read/Write requests, burns a
//            configurable number of wait states, performs the access and
//            holds MFC until the requester drops its request.
// Ports    : clock      - single clock, rising edge
//            clear      - asynchronous active-low reset
//            Read/Write - request levels, held until MFC
//            address    - word address (only [ADDR_WIDTH-1:0] used)
//            data_in    - write data from MDR
//            data_out   - read data to MDR (holds last read value)
//            MFC        - memory function complete (DONE state)
//            busy       - access in progress (BUSY state)
//            req_error  - one-cycle pulse on Read and Write both high in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module memory_responder #(
    parameter int    ADDR_WIDTH  = 9,
    parameter int    DATA_WIDTH  = 32,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [31:0]           address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  MFC,
    output logic                  busy,
    output logic                  req_error
);

    localparam int         c_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_is_write;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_mfc;
    logic                  r_busy;
    logic                  r_req_error;

    logic                  w_req_held;
    logic                  w_accept;
    logic                  w_conflict;
    logic                  w_mem_we;
    logic                  w_mem_rd;

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

    // Upper address bits are deliberately ignored, giving address wrap.
    generate
        if (ADDR_WIDTH < 32) begin : g_addr_unused
            logic w_unused_addr;
            assign w_unused_addr = ^address[31:ADDR_WIDTH];
        end
    endgenerate

    // The request that keeps an access alive is the kind that was accepted,
    // so a stray assertion of the other line mid-access is ignored.
    assign w_req_held = r_is_write ? Write : Read;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_conflict  = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_rd    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Read ^ Write) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = c_WAIT;
                    w_state_nxt = S_BUSY;
                end else if (Read && Write) begin
                    w_conflict  = 1'b1;
                end
            end
            S_BUSY: begin
                if (!w_req_held) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_mem_we    = r_is_write;
                    w_mem_rd    = ~r_is_write;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                if (!w_req_held) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_data      <= '0;
            r_is_write  <= 1'b0;
            r_data_out  <= '0;
            r_mfc       <= 1'b0;
            r_busy      <= 1'b0;
            r_req_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            if (w_accept) begin
                r_addr     <= address[ADDR_WIDTH-1:0];
                r_data     <= data_in;
                r_is_write <= Write;
            end
            if (w_mem_rd) begin
                r_data_out <= r_mem[r_addr];
            end
            // Status flags are registered copies of the next state so that
            // no input reaches an output combinationally.
            r_mfc       <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt == S_BUSY);
            r_req_error <= w_conflict;
        end
    end

    // Array has no reset; an asynchronous clear forces IDLE, so no write
    // can be issued for an access interrupted in BUSY.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_data;
        end
    end

    assign data_out  = r_data_out;
    assign MFC       = r_mfc;
    assign busy      = r_busy;
    assign req_error = r_req_error;

endmodule
`default_nettype wire
